// File: rtl/b2r_pkg.sv
// Shared definitions for the block-to-row / row-to-block converter family.
// Holds the read-FSM state encodings, the derived-size formulas and the
// core-mode word remap. Nothing here is stateful; everything is usable in
// constant expressions.
package b2r_pkg;

    // Read-side FSM encodings.
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StEmit = 2'd2;

    // Address/counter width that never collapses to zero bits.
    function automatic int unsigned clog2_safe(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    // Beats needed to cover one slice (all column groups).
    function automatic int unsigned slice_beats(input int unsigned col,
                                                input int unsigned block_size,
                                                input int unsigned num_cores_h);
        return col / (block_size * num_cores_h);
    endfunction

    // Horizontal slices per matrix.
    function automatic int unsigned num_slices(input int unsigned row,
                                               input int unsigned block_size,
                                               input int unsigned num_cores_v);
        return row / (block_size * num_cores_v);
    endfunction

    function automatic int unsigned rows_per_slice(input int unsigned block_size,
                                                   input int unsigned num_cores_v);
        return block_size * num_cores_v;
    endfunction

    // Beat word w -> output row inside its slice.
    // Word layout: w = nh*CHUNK*NV + nv*CHUNK + r*BLOCK + e.
    function automatic int unsigned remap_row(input int unsigned w,
                                              input int unsigned block_size,
                                              input int unsigned num_cores_v);
        int unsigned chunk;
        int unsigned nv;
        int unsigned r;
        chunk = block_size * block_size;
        nv    = (w / chunk) % num_cores_v;
        r     = (w % chunk) / block_size;
        return nv * block_size + r;
    endfunction

    // Beat word w of column group c -> output column.
    function automatic int unsigned remap_col(input int unsigned w,
                                              input int unsigned c,
                                              input int unsigned block_size,
                                              input int unsigned num_cores_h,
                                              input int unsigned num_cores_v);
        int unsigned chunk;
        int unsigned nh;
        int unsigned e;
        chunk = block_size * block_size;
        nh    = w / (chunk * num_cores_v);
        e     = w % block_size;
        return (c * num_cores_h + nh) * block_size + e;
    endfunction

endpackage

// File: rtl/ram_1w1r.sv
// Simple dual-port RAM: one write port, one read port, registered read data
// (1-cycle latency). Contents are not reset.
// Ports:
//   clk        clock
//   we/waddr/wdata   write enable, address, data
//   re/raddr/rdata   read enable, address, data (valid the cycle after re)
module ram_1w1r #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/b2r_converter_pp.sv
// Ping-pong block-to-row converter. Core-mode beats fill one RAM bank while
// the other bank is replayed slice by slice as row-major matrix rows.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   in_valid/in_ready/in_data     core-mode beat input (valid/ready)
//   out_valid/out_ready/out_data  one matrix row per handshake
//   out_row_idx     row number of out_data
//   out_slice_last  last row of the current slice
//   out_last        last row of the matrix
module b2r_converter_pp import b2r_pkg::*; #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned FRAC_WIDTH  = 8,
    parameter int unsigned ROW         = 256,
    parameter int unsigned COL         = 64,
    parameter int unsigned BLOCK_SIZE  = 2,
    parameter int unsigned NUM_CORES_H = 2,
    parameter int unsigned NUM_CORES_V = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE*NUM_CORES_H*NUM_CORES_V-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH*COL-1:0]      out_data,
    output logic [clog2_safe(ROW)-1:0] out_row_idx,
    output logic                      out_slice_last,
    output logic                      out_last
);

    localparam int unsigned ChunkSize    = BLOCK_SIZE * BLOCK_SIZE;
    localparam int unsigned BeatWords    = ChunkSize * NUM_CORES_H * NUM_CORES_V;
    localparam int unsigned BeatWidth    = WIDTH * BeatWords;
    localparam int unsigned SliceBeats   = slice_beats(COL, BLOCK_SIZE, NUM_CORES_H);
    localparam int unsigned NumSlices    = num_slices(ROW, BLOCK_SIZE, NUM_CORES_V);
    localparam int unsigned Beats        = SliceBeats * NumSlices;
    localparam int unsigned RowsPerSlice = rows_per_slice(BLOCK_SIZE, NUM_CORES_V);
    localparam int unsigned Depth        = 2 * Beats;
    localparam int unsigned AW           = clog2_safe(Depth);
    localparam int unsigned BW           = clog2_safe(Beats);
    localparam int unsigned SW           = clog2_safe(NumSlices);
    localparam int unsigned QW           = clog2_safe(RowsPerSlice);
    localparam int unsigned LW           = clog2_safe(SliceBeats + 1);
    localparam int unsigned RW           = clog2_safe(ROW);

    // The fraction width only travels with the data; it must fit the word.
    if (FRAC_WIDTH > WIDTH) begin : g_frac_check
        $error("FRAC_WIDTH must not exceed WIDTH");
    end

    // ---------------------------------------------------------------- write
    logic [1:0]    bank_full_q, bank_full_d;
    logic          wr_bank_q;
    logic [BW-1:0] wr_cnt_q;
    logic          wr_en, wr_last;
    logic [AW-1:0] wr_addr;

    assign in_ready = rst_n & ~bank_full_q[wr_bank_q];
    assign wr_en    = in_valid & in_ready;
    assign wr_last  = wr_en & (wr_cnt_q == BW'(Beats - 1));
    assign wr_addr  = AW'(32'(wr_bank_q) * Beats + 32'(wr_cnt_q));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
        end else if (wr_en) begin
            if (wr_last) begin
                wr_cnt_q  <= '0;
                wr_bank_q <= ~wr_bank_q;
            end else begin
                wr_cnt_q <= wr_cnt_q + BW'(1);
            end
        end
    end

    // ----------------------------------------------------------------- read
    logic [1:0]    state_q, state_d;
    logic          rd_bank_q, rd_bank_d;
    logic [SW-1:0] slice_q, slice_d;
    logic [QW-1:0] row_q, row_d;
    logic [LW-1:0] ld_q, ld_d;
    logic          emit, out_hs, row_end, slice_end, drain_done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [BeatWidth-1:0] rd_data;
    logic [BeatWidth-1:0] slice_buf [SliceBeats];
    logic [WIDTH*COL-1:0] row_data;

    assign emit       = (state_q == StEmit);
    assign out_hs     = emit & out_ready;
    assign row_end    = (row_q == QW'(RowsPerSlice - 1));
    assign slice_end  = (slice_q == SW'(NumSlices - 1));
    assign drain_done = out_hs & row_end & slice_end;

    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        slice_d   = slice_q;
        row_d     = row_q;
        ld_d      = ld_q;
        case (state_q)
            StIdle: begin
                if (bank_full_q[rd_bank_q]) begin
                    state_d = StLoad;
                    ld_d    = '0;
                end
            end
            StLoad: begin
                // One extra cycle after the last read captures its data.
                if (ld_q == LW'(SliceBeats)) begin
                    state_d = StEmit;
                    row_d   = '0;
                end else begin
                    ld_d = ld_q + LW'(1);
                end
            end
            StEmit: begin
                if (out_hs) begin
                    if (row_end) begin
                        row_d = '0;
                        ld_d  = '0;
                        if (slice_end) begin
                            state_d   = StIdle;
                            slice_d   = '0;
                            rd_bank_d = ~rd_bank_q;
                        end else begin
                            state_d = StLoad;
                            slice_d = slice_q + SW'(1);
                        end
                    end else begin
                        row_d = row_q + QW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Set and clear always hit different banks, so both can apply together.
    always_comb begin
        bank_full_d = bank_full_q;
        if (drain_done) begin
            bank_full_d[rd_bank_q] = 1'b0;
        end
        if (wr_last) begin
            bank_full_d[wr_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rd_bank_q   <= 1'b0;
            slice_q     <= '0;
            row_q       <= '0;
            ld_q        <= '0;
            bank_full_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_bank_q   <= rd_bank_d;
            slice_q     <= slice_d;
            row_q       <= row_d;
            ld_q        <= ld_d;
            bank_full_q <= bank_full_d;
        end
    end

    assign rd_en   = (state_q == StLoad) & (ld_q < LW'(SliceBeats));
    assign rd_addr = AW'(32'(rd_bank_q) * Beats + 32'(slice_q) * SliceBeats + 32'(ld_q));

    ram_1w1r #(
        .WIDTH      (BeatWidth),
        .DEPTH      (Depth),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (in_data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Data read at ld_q-1 is on rd_data while ld_q is current.
    always_ff @(posedge clk) begin
        if (state_q == StLoad) begin
            for (int unsigned i = 0; i < SliceBeats; i++) begin
                if (32'(ld_q) == i + 1) begin
                    slice_buf[i] <= rd_data;
                end
            end
        end
    end

    // Pick every slice word whose remapped row matches the current row.
    always_comb begin
        row_data = '0;
        for (int unsigned c = 0; c < SliceBeats; c++) begin
            for (int unsigned w = 0; w < BeatWords; w++) begin
                if (remap_row(w, BLOCK_SIZE, NUM_CORES_V) == 32'(row_q)) begin
                    row_data[remap_col(w, c, BLOCK_SIZE, NUM_CORES_H, NUM_CORES_V) * WIDTH +: WIDTH]
                        = slice_buf[c][w * WIDTH +: WIDTH];
                end
            end
        end
    end

    assign out_valid      = emit;
    assign out_data       = emit ? row_data : '0;
    assign out_row_idx    = emit ? RW'(32'(slice_q) * RowsPerSlice + 32'(row_q)) : '0;
    assign out_slice_last = emit & row_end;
    assign out_last       = emit & row_end & slice_end;

endmodule

// File: tb/tb_b2r_converter_pp.sv
module tb_b2r_converter_pp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Small configuration: ROW=COL=8, 4 beats, 8 rows.
    logic         s_rst_n, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic         s_out_slice_last, s_out_last;
    logic [255:0] s_in_data;
    logic [127:0] s_out_data;
    logic [2:0]   s_out_row_idx;

    // Default configuration: ROW=256, COL=64, 1024 beats.
    logic          b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic          b_out_slice_last, b_out_last;
    logic [255:0]  b_in_data;
    logic [1023:0] b_out_data;
    logic [7:0]    b_out_row_idx;

    b2r_converter_pp #(
        .WIDTH(16), .FRAC_WIDTH(8), .ROW(8), .COL(8),
        .BLOCK_SIZE(2), .NUM_CORES_H(2), .NUM_CORES_V(2)
    ) u_small (
        .clk            (clk),
        .rst_n          (s_rst_n),
        .in_valid       (s_in_valid),
        .in_ready       (s_in_ready),
        .in_data        (s_in_data),
        .out_valid      (s_out_valid),
        .out_ready      (s_out_ready),
        .out_data       (s_out_data),
        .out_row_idx    (s_out_row_idx),
        .out_slice_last (s_out_slice_last),
        .out_last       (s_out_last)
    );

    b2r_converter_pp u_big (
        .clk            (clk),
        .rst_n          (b_rst_n),
        .in_valid       (b_in_valid),
        .in_ready       (b_in_ready),
        .in_data        (b_in_data),
        .out_valid      (b_out_valid),
        .out_ready      (b_out_ready),
        .out_data       (b_out_data),
        .out_row_idx    (b_out_row_idx),
        .out_slice_last (b_out_slice_last),
        .out_last       (b_out_last)
    );

    typedef struct packed {
        logic [127:0] data;
        logic [2:0]   idx;
        logic         slast;
        logic         last;
    } s_exp_t;

    typedef struct packed {
        logic [1023:0] data;
        logic [7:0]    idx;
        logic          slast;
        logic          last;
    } b_exp_t;

    s_exp_t s_q[$];
    b_exp_t b_q[$];
    logic [15:0] big_mat [256][64];

    int unsigned s_last_hs_cyc, s_first_hs_cyc, s_stalls, s_outlast_hs_cyc;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Core-mode layout for BLOCK=NH=NV=2: slice s / column group c / word w.
    function automatic int unsigned tb_row(input int unsigned s, input int unsigned w);
        return s * 4 + ((w / 4) % 2) * 2 + (w % 4) / 2;
    endfunction

    function automatic int unsigned tb_col(input int unsigned c, input int unsigned w);
        return (c * 2 + w / 8) * 2 + w % 2;
    endfunction

    // Matrix element (r, col) = off + r*8 + col.
    task automatic s_push_exp(input int unsigned off);
        s_exp_t e;
        for (int unsigned r = 0; r < 8; r++) begin
            e.data = '0;
            for (int unsigned j = 0; j < 8; j++) e.data[j*16 +: 16] = 16'(off + r * 8 + j);
            e.idx   = 3'(r);
            e.slast = (r % 4 == 3);
            e.last  = (r == 7);
            s_q.push_back(e);
        end
    endtask

    task automatic s_send(input int unsigned off, input int unsigned n, input bit keep);
        logic [255:0] d;
        int unsigned k;
        s_stalls = 0;
        for (int unsigned b = 0; b < n; b++) begin
            d = '0;
            for (int unsigned w = 0; w < 16; w++)
                d[w*16 +: 16] = 16'(off + tb_row(b / 2, w) * 8 + tb_col(b % 2, w));
            s_in_data  = d;
            s_in_valid = 1'b1;
            k = 0;
            @(negedge clk);
            while (!s_in_ready && k < 300) begin
                s_stalls++;
                k++;
                @(negedge clk);
            end
            if (!s_in_ready) begin
                fail_now("s_in_accept");
                s_in_valid = 1'b0;
                return;
            end
            if (b == 0) s_first_hs_cyc = cyc;
            s_last_hs_cyc = cyc;
            @(posedge clk);
            #1;
        end
        if (!keep) s_in_valid = 1'b0;
    endtask

    task automatic s_drain();
        int unsigned k;
        k = 0;
        while (s_q.size() != 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (s_q.size() != 0) fail_now("s_drain");
        @(posedge clk);
        #1;
    endtask

    // Monitors: every valid cycle is compared with the queue head, so a
    // stalled row that changes is caught; the head pops on the handshake.
    always @(negedge clk) begin
        if (s_rst_n && s_out_valid) begin
            if (s_q.size() == 0) begin
                fail_now("s_unexpected_row");
            end else begin
                chk("s_data", s_out_data, s_q[0].data);
                chk("s_row_idx", s_out_row_idx, s_q[0].idx);
                chk("s_slice_last", s_out_slice_last, s_q[0].slast);
                chk("s_last", s_out_last, s_q[0].last);
                if (s_out_ready) begin
                    if (s_out_last) s_outlast_hs_cyc = cyc;
                    void'(s_q.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (b_rst_n && b_out_valid) begin
            if (b_q.size() == 0) begin
                fail_now("b_unexpected_row");
            end else begin
                for (int k = 0; k < 4; k++)
                    chk("b_data", b_out_data[k*256 +: 256], b_q[0].data[k*256 +: 256]);
                chk("b_row_idx", b_out_row_idx, b_q[0].idx);
                chk("b_slice_last", b_out_slice_last, b_q[0].slast);
                chk("b_last", b_out_last, b_q[0].last);
                if (b_out_ready) void'(b_q.pop_front());
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k;
        int unsigned lat;
        bit done;
        logic [255:0] d;
        b_exp_t be;

        s_rst_n = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
        b_rst_n = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", s_out_valid, 1'b0);
        chk("rst_in_ready", s_in_ready, 1'b0);
        chk("rst_out_data", s_out_data, '0);
        chk("rst_row_idx", s_out_row_idx, '0);
        chk("rst_slice_last", s_out_slice_last, 1'b0);
        chk("rst_last", s_out_last, 1'b0);
        chk("rst_b_out_valid", b_out_valid, 1'b0);
        @(posedge clk);
        #1;
        s_rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", s_in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Single matrix, ready held high, first-row latency.
        s_push_exp(0);
        s_send(0, 4, 1'b0);
        k = 0;
        @(negedge clk);
        while (!s_out_valid && k < 30) begin
            k++;
            @(negedge clk);
        end
        lat = cyc - s_last_hs_cyc;
        chk("s_first_latency", lat, 5);
        s_drain();

        // Two back-to-back matrices with in_valid held high.
        s_push_exp(64);
        s_push_exp(128);
        s_send(64, 4, 1'b1);
        s_send(128, 4, 1'b0);
        chk("s_b2b_stalls", s_stalls, 0);
        s_drain();

        // Three matrices with the output stalled: the third waits for a bank.
        s_out_ready = 1'b0;
        s_push_exp(500);
        s_push_exp(600);
        s_push_exp(700);
        s_send(500, 4, 1'b1);
        s_send(600, 4, 1'b1);
        @(negedge clk);
        chk("s_full_in_ready", s_in_ready, 1'b0);
        @(posedge clk);
        #1;
        fork
            s_send(700, 4, 1'b0);
            begin
                repeat (20) @(posedge clk);
                #1;
                s_out_ready = 1'b1;
            end
        join
        chk("s_beat9_after_out_last", s_first_hs_cyc - s_outlast_hs_cyc, 1);
        s_drain();

        // Random backpressure.
        s_push_exp(800);
        s_push_exp(900);
        done = 1'b0;
        fork
            begin
                s_send(800, 4, 1'b1);
                s_send(900, 4, 1'b0);
                s_drain();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    s_out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        s_out_ready = 1'b1;

        // Reset while matrix 1 is presenting and matrix 2 is half written.
        s_out_ready = 1'b0;
        s_push_exp(300);
        s_send(300, 4, 1'b0);
        k = 0;
        @(negedge clk);
        while (!s_out_valid && k < 30) begin
            k++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        s_send(400, 2, 1'b0);
        s_rst_n = 1'b0;
        s_q.delete();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_out_valid", s_out_valid, 1'b0);
        chk("midrst_in_ready", s_in_ready, 1'b0);
        @(posedge clk);
        #1;
        s_rst_n = 1'b1;
        s_out_ready = 1'b1;
        s_push_exp(1000);
        s_send(1000, 4, 1'b0);
        s_drain();

        // Default configuration, one random matrix.
        b_rst_n = 1'b1;
        for (int unsigned r = 0; r < 256; r++)
            for (int unsigned c = 0; c < 64; c++) big_mat[r][c] = 16'($urandom);
        for (int unsigned r = 0; r < 256; r++) begin
            be.data = '0;
            for (int unsigned j = 0; j < 64; j++) be.data[j*16 +: 16] = big_mat[r][j];
            be.idx   = 8'(r);
            be.slast = (r % 4 == 3);
            be.last  = (r == 255);
            b_q.push_back(be);
        end
        @(posedge clk);
        #1;
        for (int unsigned b = 0; b < 1024; b++) begin
            d = '0;
            for (int unsigned w = 0; w < 16; w++)
                d[w*16 +: 16] = big_mat[tb_row(b / 16, w)][tb_col(b % 16, w)];
            b_in_data  = d;
            b_in_valid = 1'b1;
            k = 0;
            @(negedge clk);
            while (!b_in_ready && k < 100) begin
                k++;
                @(negedge clk);
            end
            if (!b_in_ready) begin
                fail_now("b_in_accept");
                break;
            end
            @(posedge clk);
            #1;
        end
        b_in_valid = 1'b0;
        k = 0;
        while (b_q.size() != 0 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (b_q.size() != 0) fail_now("b_drain");
        repeat (5) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/b2r_converter_pp.md
Name: b2r_converter_pp

Overview:
- Parametrised successor to the single-matrix block-to-row converter in the self-attention head.
- Accepts core-mode beats (one chunk per core per beat) and emits matrix rows in normal row-major order.
- New behaviour:
  - Ping-pong double buffering: matrix k+1 fills while matrix k drains.
  - Valid/ready handshakes on both sides.
  - Per-row index and last-row flags, so it runs continuously across back-to-back matrices.

Parameters:
- WIDTH, 16: element width in bits.
- FRAC_WIDTH, 8: fixed-point fraction bits; pass-through only, no arithmetic.
- ROW, 256: matrix rows; multiple of BLOCK_SIZE*NUM_CORES_V.
- COL, 64: matrix columns; multiple of BLOCK_SIZE*NUM_CORES_H.
- BLOCK_SIZE, 2: core block edge. Derived CHUNK_SIZE = BLOCK_SIZE*BLOCK_SIZE, which is one block stored row-major.
- NUM_CORES_H, 2: horizontal core count.
- NUM_CORES_V, 2: vertical core count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  write bank can accept a beat.
- in_data  in  WIDTH*CHUNK_SIZE*NUM_CORES_H*NUM_CORES_V  core-mode beat.
- out_valid  out  1  out_data holds a valid row.
- out_ready  in  1  downstream accepts the row.
- out_data  out  WIDTH*COL  one matrix row; element j at bits [j*WIDTH +: WIDTH].
- out_row_idx  out  clog2(ROW)  row number of out_data.
- out_slice_last  out  1  last row of the current slice.
- out_last  out  1  last row of the matrix (row ROW-1).

Behaviour:
- Derived values:
  - SLICE_BEATS = COL/(BLOCK_SIZE*NUM_CORES_H).
  - NUM_SLICES = ROW/(BLOCK_SIZE*NUM_CORES_V).
  - BEATS = SLICE_BEATS*NUM_SLICES.
  - ROWS_PER_SLICE = NUM_CORES_V*BLOCK_SIZE.
- Input order: beat b = s*SLICE_BEATS + c, where s is the slice and c the column group.
- Word index in a beat = nh*CHUNK_SIZE*NUM_CORES_V + nv*CHUNK_SIZE + r*BLOCK_SIZE + e.
- That word maps to output row s*ROWS_PER_SLICE + nv*BLOCK_SIZE + r, column (c*NUM_CORES_H + nh)*BLOCK_SIZE + e.
- Storage: one RAM of depth 2*BEATS, address {bank, beat}, 1-cycle read latency.
- Write side:
  - in_ready = rst_n & !bank_full[wr_bank].
  - On a handshake the beat is written to {wr_bank, wr_cnt} and wr_cnt increments.
  - At wr_cnt == BEATS-1 with a handshake: wr_cnt <= 0, bank_full[wr_bank] <= 1, wr_bank toggles.
  - Beats are accepted with gaps and at any rate; in_valid without in_ready is ignored.
- Read FSM states and transitions:
  - IDLE -> LOAD when bank_full[rd_bank].
  - LOAD: issue SLICE_BEATS consecutive reads of slice s and capture them into slice_buf[0..SLICE_BEATS-1] one cycle later. -> EMIT after the last capture.
  - EMIT: present row s*ROWS_PER_SLICE + q, q = 0..ROWS_PER_SLICE-1. Advance q only on out_valid & out_ready.
  - After q = ROWS_PER_SLICE-1 is accepted: -> LOAD with s+1; if s == NUM_SLICES-1 instead -> IDLE, clear bank_full[rd_bank], toggle rd_bank, s <= 0.
- Output rules:
  - out_valid is high only in EMIT.
  - out_data, out_row_idx and the flags stay stable while out_valid & !out_ready.
  - out_slice_last = (q == ROWS_PER_SLICE-1).
  - out_last = out_slice_last & (s == NUM_SLICES-1).
- Latency:
  - First out_valid is exactly SLICE_BEATS+3 cycles after the cycle of the final input handshake of a matrix.
  - Each slice costs SLICE_BEATS+1 load cycles plus ROWS_PER_SLICE emit cycles when out_ready is held high.
- Simultaneous events:
  - Write-side set and read-side clear of bank_full in one cycle target different banks; both take effect.
  - If both banks are full, in_ready = 0 until the drain completes. in_ready rises the cycle after the out_last handshake.
- Reset values: out_valid 0, out_data 0, out_row_idx 0, out_slice_last 0, out_last 0, in_ready 0 while rst_n is low.
  - Also cleared: bank_full = 0, wr_bank = rd_bank = 0, all counters 0, FSM IDLE.
  - Reset mid-operation discards both banks. RAM contents are not cleared.

Decomposition:
- Shared package/header b2r_pkg:
  - clog2_safe function (returns 1 for inputs <= 1).
  - Derived-constant formulas and FSM state encodings, reused by r2b/b2r variants.
- Sub-module: existing ram_1w1r, instantiated once with DEPTH = 2*BEATS.
- Index remap (beat word -> row column) is a combinational function in b2r_pkg, not a module.

Test Plan:
- Test configuration: ROW=8, COL=8, BLOCK=2, NH=NV=2, so BEATS=4, SLICE_BEATS=2, 8 output rows.
- Single matrix, word value = global element index r*8+c, out_ready=1:
  - rows 0..7 equal {8r..8r+7};
  - first out_valid 5 cycles after the 4th beat;
  - out_slice_last on rows 3 and 7, out_last on row 7.
- Two back-to-back matrices (second offset +64), in_valid held high:
  - in_ready never drops during matrix 2;
  - matrix 2 rows follow matrix 1 rows with correct out_row_idx reset to 0.
- Three matrices, out_ready=0 throughout:
  - in_ready drops after beat 8;
  - beat 9 is held until the matrix-1 out_last handshake, then accepted.
- Random out_ready (50%):
  - out_data and out_row_idx are stable whenever valid & !ready;
  - row sequence matches the golden model.
- rst_n pulled low after beat 2 of matrix 2 while matrix 1 is draining:
  - next cycle out_valid=0 and in_ready=0;
  - after release, a fresh matrix converts correctly.
- Default parameters (ROW=256, COL=64), one matrix with random data:
  - 256 rows match the golden remap;
  - out_last asserts only on row 255.
